// File: rtl/arp_crypto_verify.sv
// arp_crypto_verify: checks the 128-bit tag carried in beat 2 of ARP frames.
// ARP frames with a matching tag are forwarded after a one-beat hold.
// ARP frames with a missing or wrong tag are dropped whole.
// Other traffic passes through combinationally.
// Optional build macro: ARP_VERIFY_STRIP_EN. When it is defined, the tag field
// of forwarded beat 2 is zeroed so the tag never leaves the block.
module arp_crypto_verify #(
  parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128
) (
  input  logic                                 axis_aclk,
  input  logic                                 axis_reset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_tdata,
  input  logic [(C_S_AXIS_DATA_WIDTH/8)-1:0]   s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser,
  input  logic                                 s_axis_tvalid,
  input  logic                                 s_axis_tlast,
  output logic                                 s_axis_tready,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
  output logic [(C_M_AXIS_DATA_WIDTH/8)-1:0]   m_axis_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser,
  output logic                                 m_axis_tvalid,
  output logic                                 m_axis_tlast,
  input  logic                                 m_axis_tready,
  input  logic [31:0]                          key_word0,
  input  logic [31:0]                          key_word1,
  input  logic [31:0]                          key_word2,
  input  logic [31:0]                          key_word3,
  input  logic                                 cnt_clear,
  output logic [31:0]                          arp_pass_cnt,
  output logic [31:0]                          arp_drop_cnt
);

  localparam int unsigned DATA_W  = C_S_AXIS_DATA_WIDTH;
  localparam int unsigned KEEP_W  = C_S_AXIS_DATA_WIDTH / 8;
  localparam int unsigned USER_W  = C_S_AXIS_TUSER_WIDTH;
  localparam int unsigned TAG_LSB = 80;
  localparam int unsigned TAG_MSB = 207;
  localparam int unsigned ET_LSB  = 96;
  localparam int unsigned ET_MSB  = 111;

  localparam logic [15:0] ARP_ETHERTYPE = 16'h0608;

  // Ones over the tag field of beat 2.
  localparam logic [DATA_W-1:0] TAG_MASK =
    DATA_W'({(TAG_MSB - TAG_LSB + 1){1'b1}}) << TAG_LSB;
`ifdef ARP_VERIFY_STRIP_EN
  localparam logic [DATA_W-1:0] STRIP_MASK = ~TAG_MASK;
`else
  localparam logic [DATA_W-1:0] STRIP_MASK = {DATA_W{1'b1}};
`endif

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HOLD = 3'd1;
  localparam logic [2:0] S_ARP2 = 3'd2;
  localparam logic [2:0] S_PASS = 3'd3;
  localparam logic [2:0] S_DROP = 3'd4;

  typedef struct packed {
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic [USER_W-1:0] tuser;
    logic              tlast;
  } beat_t;

  logic [2:0]  state;
  logic [2:0]  nxt_state;
  beat_t       hold;
  logic        is_arp;
  logic        tag_match;
  logic        out_valid;
  logic        sel_hold;
  logic        strip;
  logic        capture;
  logic        pass_inc;
  logic        drop_inc;
  logic [31:0] pass_cnt_q;
  logic [31:0] drop_cnt_q;

  assign is_arp    = (s_axis_tdata[ET_MSB:ET_LSB] == ARP_ETHERTYPE);
  assign tag_match = (s_axis_tdata[TAG_MSB:TAG_LSB] ==
                      {key_word0, key_word1, key_word2, key_word3});

  assign arp_pass_cnt = pass_cnt_q;
  assign arp_drop_cnt = drop_cnt_q;

  // State register.
  always_ff @(posedge axis_aclk) begin
    if (axis_reset) state <= S_IDLE;
    else            state <= nxt_state;
  end

  // Next-state, handshake and counter-event decode.
  always_comb begin
    nxt_state     = state;
    s_axis_tready = 1'b0;
    out_valid     = 1'b0;
    sel_hold      = 1'b0;
    strip         = 1'b0;
    capture       = 1'b0;
    pass_inc      = 1'b0;
    drop_inc      = 1'b0;
    case (state)
      S_IDLE: begin
        if (s_axis_tvalid && is_arp) begin
          s_axis_tready = 1'b1;
          capture       = 1'b1;
          if (s_axis_tlast) drop_inc  = 1'b1;
          else              nxt_state = S_HOLD;
        end else begin
          s_axis_tready = m_axis_tready;
          out_valid     = s_axis_tvalid;
          if (s_axis_tvalid && m_axis_tready && !s_axis_tlast) nxt_state = S_PASS;
        end
      end
      S_HOLD: begin
        if (s_axis_tvalid) begin
          if (tag_match) begin
            out_valid = 1'b1;
            sel_hold  = 1'b1;
            if (m_axis_tready) nxt_state = S_ARP2;
          end else begin
            s_axis_tready = 1'b1;
            drop_inc      = 1'b1;
            nxt_state     = s_axis_tlast ? S_IDLE : S_DROP;
          end
        end
      end
      S_ARP2: begin
        s_axis_tready = m_axis_tready;
        out_valid     = s_axis_tvalid;
        strip         = 1'b1;
        if (s_axis_tvalid && m_axis_tready) begin
          pass_inc  = 1'b1;
          nxt_state = s_axis_tlast ? S_IDLE : S_PASS;
        end
      end
      S_PASS: begin
        s_axis_tready = m_axis_tready;
        out_valid     = s_axis_tvalid;
        if (s_axis_tvalid && m_axis_tready && s_axis_tlast) nxt_state = S_IDLE;
      end
      S_DROP: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) nxt_state = S_IDLE;
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  // Egress mux: held beat 1 or live input; payload forced to zero while idle.
  always_comb begin
    m_axis_tvalid = out_valid;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tuser  = '0;
    m_axis_tlast  = 1'b0;
    if (out_valid) begin
      if (sel_hold) begin
        m_axis_tdata = hold.tdata;
        m_axis_tkeep = hold.tkeep;
        m_axis_tuser = hold.tuser;
        m_axis_tlast = hold.tlast;
      end else begin
        m_axis_tdata = strip ? (s_axis_tdata & STRIP_MASK) : s_axis_tdata;
        m_axis_tkeep = s_axis_tkeep;
        m_axis_tuser = s_axis_tuser;
        m_axis_tlast = s_axis_tlast;
      end
    end
  end

  // Holding register for beat 1 of an ARP frame.
  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      hold <= '0;
    end else if (capture) begin
      hold <= '{tdata: s_axis_tdata, tkeep: s_axis_tkeep,
                tuser: s_axis_tuser, tlast: s_axis_tlast};
    end
  end

  // Pass/drop counters; clear wins over a same-cycle increment.
  always_ff @(posedge axis_aclk) begin
    if (axis_reset || cnt_clear) begin
      pass_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (pass_inc) pass_cnt_q <= pass_cnt_q + 32'd1;
      if (drop_inc) drop_cnt_q <= drop_cnt_q + 32'd1;
    end
  end

endmodule

// File: doc/arp_crypto_verify.md
# arp_crypto_verify

Receive-side counterpart of the ARP tag-insertion stage: it checks the 128-bit authentication tag that the transmit side places in beat 2 of every ARP frame. Frames with a matching tag are forwarded; frames with a missing or wrong tag are dropped whole. Non-ARP traffic passes through with zero added latency. The block sits on the 256-bit AXI4-Stream datapath between the RX queues and the output port lookup, and takes its key from the block's CPU register file.

## Interface
Parameters:
- C_M_AXIS_DATA_WIDTH, 256, master tdata width (only 256 supported)
- C_S_AXIS_DATA_WIDTH, 256, slave tdata width (must equal master)
- C_M_AXIS_TUSER_WIDTH, 128, master tuser width
- C_S_AXIS_TUSER_WIDTH, 128, slave tuser width

Ports:
- axis_aclk  in  1  single clock for all logic
- axis_reset  in  1  reset; synchronous, active-high
- s_axis_tdata/tkeep/tuser/tvalid/tlast  in  256/32/128/1/1  ingress stream
- s_axis_tready  out  1  ingress backpressure
- m_axis_tdata/tkeep/tuser/tvalid/tlast  out  256/32/128/1/1  egress stream
- m_axis_tready  in  1  egress backpressure
- key_word0..key_word3  in  32 each  expected tag words, quasi-static, from the CPU register file
- cnt_clear  in  1  synchronous clear of both counters
- arp_pass_cnt  out  32  ARP frames accepted
- arp_drop_cnt  out  32  ARP frames dropped

## Operation
- ARP detection: first beat with s_axis_tdata[111:96] == 16'h0608.
- Tag location: beat 2, bits [207:80].
  - key_word0 → [207:176]
  - key_word1 → [175:144]
  - key_word2 → [143:112]
  - key_word3 → [111:80]
- Holding register: one 256+32+128+1-bit register holds beat 1 of an ARP frame.
- States:
  - IDLE:
    - Non-ARP valid first beat: forwarded combinationally (m_valid = s_valid, s_ready = m_ready). On transfer, go to PASS; stay in IDLE if tlast.
    - ARP first beat: s_ready = 1, beat captured into the holding register, m_valid = 0. Go to HOLD. If tlast is set (one-beat ARP), the frame is dropped: arp_drop_cnt +1, stay in IDLE.
  - HOLD: s_ready = 0 until s_valid. The tag is compared combinationally against the unconsumed s_axis_tdata.
    - Match: drive the held beat, m_valid = 1. On m_ready, go to ARP2.
    - Mismatch: s_ready = 1, beat 2 consumed and discarded, arp_drop_cnt +1. Go to DROP, or to IDLE if beat 2 has tlast.
  - ARP2: forward beat 2 combinationally, with tag bytes modified per the Configuration section. On transfer, arp_pass_cnt +1; go to IDLE if tlast, else PASS.
  - PASS: combinational forwarding. On tlast transfer, go to IDLE.
  - DROP: s_ready = 1, m_valid = 0, discard beats. On tlast, go to IDLE.
- Beat 2 is never consumed before its decision is made. AXI-Stream stability of s_axis_tdata makes the late compare legal.
- Key words are sampled in HOLD only. A key change mid-frame does not affect the decision once the frame has left HOLD.
- Counters:
  - 32-bit, wrap from 0xFFFFFFFF to 0.
  - cnt_clear has priority over a same-cycle increment (result is 0).

## Timing
- Reset values:
  - state = IDLE, counters = 0, holding register = 0.
  - m_axis_tvalid = 0, m_axis_tdata/tkeep/tuser/tlast = 0 while not valid.
  - s_axis_tready = m_axis_tready in IDLE.
- Latency:
  - Non-ARP: 0 cycles (combinational).
  - ARP: beat 1 emitted ≥1 cycle after capture. Minimum is 1 bubble per ARP frame.
- No combinational path from m_axis_tready to m_axis_tvalid. The only ready→ready path is the pass-through.
- Reset asserted mid-frame: state returns to IDLE within the same edge, and the frame is abandoned. The remaining beats are parsed as a new frame. This is accepted behaviour, and the bench checks it.
- Backpressure while holding beat 1 (m_ready = 0): beat 1 is retained indefinitely and s_ready stays 0.

## Configuration
- ARP_VERIFY_STRIP_EN:
  - Defined: bits [207:80] of forwarded beat 2 are zeroed, so the tag never leaves the block.
  - Undefined: beat 2 is forwarded unmodified.
- Pass/drop decisions and counters are identical in both builds.

## Test plan
- Non-ARP frame, 3 beats, m_ready = 1: output identical, same cycles, zero latency. Counters stay 0.
- ARP frame, 2 beats, key = {0x11111111, 0x22222222, 0x33333333, 0x44444444}, correct tag: both beats out, 1-cycle bubble, arp_pass_cnt = 1. Beat 2 [207:80] = 0 with ARP_VERIFY_STRIP_EN, else equal to the input.
- ARP frame, 4 beats, tag with one bit flipped (key_word3 ^ 1): no output beats, all 4 consumed, arp_drop_cnt = 1. A following non-ARP frame passes intact.
- One-beat ARP with tlast on beat 1: consumed, nothing output, arp_drop_cnt = 1.
- Matching ARP with m_ready = 0 for 5 cycles in HOLD: beat 1 held, s_ready = 0, no beat lost or duplicated once m_ready rises.
- arp_pass_cnt preloaded to 0xFFFFFFFF by forcing, then one matching ARP: wraps to 0. Asserting cnt_clear in the same cycle as an increment yields 0. Assert axis_reset during DROP: state is IDLE next cycle.
